// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multi-cycle multiply/divide engine for the EX stage
// Optional single-cycle multiplier: define MULDIV_FAST_MUL_EN.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int ITERS = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic            i_flush,
   output logic            o_stall,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(ITERS);

   localparam logic [2:0] F_MUL = 3'b000;
   localparam logic [2:0] F_DIV = 3'b100;
   localparam logic [2:0] F_REM = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_funct3;
   logic              r_neg;
   logic [XLEN-1:0]   r_opnd;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_result;

   logic              w_is_div;
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic              w_neg;
   logic              w_div0;
   logic              w_ovf;
   logic              w_fast;
   logic [XLEN-1:0]   w_fast_res;
   logic              w_accept;
   logic              w_last;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_diff;
   logic [2*XLEN-1:0] w_acc_nxt;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_calc_res;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     w_fm_a;
   logic signed [XLEN:0]     w_fm_b;
   logic signed [2*XLEN-1:0] w_fm_ax;
   logic signed [2*XLEN-1:0] w_fm_bx;
   logic signed [2*XLEN-1:0] w_fm_prod;
`endif

   // Operand decode: signedness, magnitudes and the final negate flag
   always_comb begin
      w_is_div   = i_funct3[2];
      w_a_signed = w_is_div ? !i_funct3[0] : (i_funct3 != 3'b011);
      w_b_signed = w_is_div ? !i_funct3[0] : !i_funct3[1];
      w_sa       = w_a_signed & i_op_a[XLEN-1];
      w_sb       = w_b_signed & i_op_b[XLEN-1];
      w_a_mag    = w_sa ? -i_op_a : i_op_a;
      w_b_mag    = w_sb ? -i_op_b : i_op_b;
      w_neg      = (w_is_div && i_funct3[1]) ? w_sa : (w_sa ^ w_sb);
      w_div0     = w_is_div && (i_op_b == '0);
      w_ovf      = ((i_funct3 == F_DIV) || (i_funct3 == F_REM)) &&
                   (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_op_b == '1);
      w_fast     = w_div0 || w_ovf;
      w_fast_res = '0;
      if (w_div0)
         w_fast_res = i_funct3[1] ? i_op_a : '1;
      else if (w_ovf)
         w_fast_res = i_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
      w_fm_a    = {w_a_signed & i_op_a[XLEN-1], i_op_a};
      w_fm_b    = {w_b_signed & i_op_b[XLEN-1], i_op_b};
      w_fm_ax   = {{(XLEN-1){w_fm_a[XLEN]}}, w_fm_a};
      w_fm_bx   = {{(XLEN-1){w_fm_b[XLEN]}}, w_fm_b};
      w_fm_prod = w_fm_ax * w_fm_bx;
      if (!w_is_div) begin
         w_fast     = 1'b1;
         w_fast_res = (i_funct3 == F_MUL) ? w_fm_prod[XLEN-1:0] : w_fm_prod[2*XLEN-1:XLEN];
      end
`endif
   end

   // One radix-2 step; r_acc holds {hi, lo} for both the product and remainder/quotient
   always_comb begin
      w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
      w_shift = r_acc[2*XLEN-1:XLEN-1];
      w_diff  = w_shift - {1'b0, r_opnd};
      if (r_funct3[2]) begin
         if (!w_diff[XLEN])
            w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
         else
            w_acc_nxt = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end else begin
         w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
      end
      w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
      w_quo  = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
      w_rem  = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
      if (r_funct3[2])
         w_calc_res = r_funct3[1] ? w_rem : w_quo;
      else
         w_calc_res = (r_funct3 == F_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   end

   assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
   assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(ITERS-1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
         S_CALC:  if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (i_flush)
         w_next = S_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_funct3 <= '0;
         r_neg    <= 1'b0;
         r_opnd   <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_funct3 <= i_funct3;
            r_neg    <= w_neg;
            r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
            r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_cnt    <= '0;
            if (w_fast)
               r_result <= w_fast_res;
         end else if ((r_state == S_CALC) && !i_flush) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last)
               r_result <= w_calc_res;
         end
      end
   end

   assign o_stall  = i_reset && (w_accept || (r_state == S_CALC));
   assign o_done   = i_reset && (r_state == S_DONE) && !i_flush;
   assign o_result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

   logic        clk;
   logic        i_reset;
   logic        i_start;
   logic [2:0]  i_funct3;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic        i_flush;
   logic        o_stall;
   logic        o_done;
   logic [31:0] o_result;

   int checks = 0;
   int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb[$];
   logic [31:0] last_exp;

   ex_muldiv_unit dut (
      .i_clk    (clk),
      .i_reset  (i_reset),
      .i_start  (i_start),
      .i_funct3 (i_funct3),
      .i_op_a   (i_op_a),
      .i_op_b   (i_op_b),
      .i_flush  (i_flush),
      .o_stall  (o_stall),
      .o_done   (o_done),
      .o_result (o_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: each o_done pulse pops one expected result
   always @(negedge clk) begin
      logic [31:0] e;
      if (o_done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_done: o_done with no pending op, result=%h", o_result);
         end else begin
            e = sb.pop_front();
            if (o_result !== e) begin
               errors++;
               $display("FAIL result: got %h expected %h", o_result, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input int idx);
      int n;
      int stall_cnt;
      int lat;
      bit got;
      n = 0; stall_cnt = 0; lat = 0; got = 0;
      i_funct3 = v.f; i_op_a = v.a; i_op_b = v.b; i_start = 1'b1;
      sb.push_back(v.exp);
      while (n < 100 && !got) begin
         @(negedge clk);
         if (o_stall) stall_cnt++;
         if (o_done) begin got = 1; lat = n; end
         @(posedge clk); #1;
         n++;
         i_start = 1'b0;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL timeout vec%0d: no o_done after %0d cycles", idx, n);
      end
      check($sformatf("latency vec%0d", idx), lat, v.lat);
      check($sformatf("stall_cycles vec%0d", idx), stall_cnt, v.lat);
   endtask

   initial begin
      int n;
      int nd;
      int d[2];

      vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, ML});
      vecs.push_back('{3'b011, 32'd7,        32'hFFFFFFFD, 32'h00000006, ML});
      vecs.push_back('{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, ML});
      vecs.push_back('{3'b010, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, ML});
      vecs.push_back('{3'b010, 32'd7,        32'hFFFFFFFD, 32'h00000006, ML});
      vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML});
      vecs.push_back('{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, ML});
      vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
      vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
      vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       33});
      vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        33});
      vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33});
      vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33});
      vecs.push_back('{3'b100, 32'h1234,     32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{3'b110, 32'h1234,     32'd0,        32'h00001234, 1});
      vecs.push_back('{3'b111, 32'h1234,     32'd0,        32'h00001234, 1});
      vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
      vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
      vecs.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
      vecs.push_back('{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});

      // Reset held with a pending start
      i_reset = 1'b0; i_start = 1'b1; i_flush = 1'b0;
      i_funct3 = 3'b000; i_op_a = 32'd7; i_op_b = 32'hFFFFFFFD;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("reset_stall", {31'b0, o_stall}, 32'd0);
         check("reset_done", {31'b0, o_done}, 32'd0);
         check("reset_result", o_result, 32'd0);
      end
      @(posedge clk); #1;
      i_reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_op(vecs[i], i);
      last_exp = vecs[vecs.size()-1].exp;

      // Flush during CALC at counter 10
      i_funct3 = 3'b101; i_op_a = 32'd100; i_op_b = 32'd7; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
      end
      i_flush = 1'b1;
      @(negedge clk);
      check("flush_calc_stall", {31'b0, o_stall}, 32'd1);
      @(posedge clk); #1;
      i_flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("flush_stall", {31'b0, o_stall}, 32'd0);
         check("flush_result_held", o_result, last_exp);
      end
      for (int k = 0; k < 40; k++) @(posedge clk);
      #1;

      // Back-to-back MULH, start held continuously
      sb.push_back(32'h40000000);
      sb.push_back(32'h00000000);
      i_funct3 = 3'b001; i_op_a = 32'h80000000; i_op_b = 32'h80000000; i_start = 1'b1;
      @(posedge clk); #1;
      i_op_a = 32'd3; i_op_b = 32'd5;
      n = 1; nd = 0; d[0] = 0; d[1] = 0;
      while (n < 200 && nd < 2) begin
         @(negedge clk);
         if (o_done) begin
            d[nd] = n;
            nd++;
            if (nd == 2) i_start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      i_start = 1'b0;
      check("b2b_done_count", nd, 2);
      check("b2b_first_latency", d[0], ML);
      check("b2b_gap", d[1] - d[0], ML + 1);

      for (int k = 0; k < 10; k++) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
